or1200_shadowstk_rs: RTL
========================

Name: or1200_shadowstk_rs

Overview:
Parametrised hardware return-address shadow stack for the OR1200 pipeline, successor to the single-width debug-only shadow stack.
- Push: link addresses are pushed on committed calls (l.jal / l.jalr).
- Pop and compare: on committed returns (l.jr r9), the top entry is popped and compared with the actual return target.
- Result: a registered check result, sticky overflow/underflow status, and an optional fault request to the exception unit.
- Placement: beside or1200_ctrl, fed by decoded EX-stage strobes.

Parameters:
AW, 32, address width of stored and compared entries
DEPTH, 16, number of entries (power of two, 2..256)
CW, 5, occupancy counter width (log2(DEPTH)+1)
OVF_WRAP, 1, 1 = circular (overwrite oldest on full push), 0 = saturate (drop push on full)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
ex_freeze  in  1  pipeline freeze; all strobes ignored while high
enable  in  1  block enable; when low, push/pop are ignored and state is held
fault_en  in  1  allow fault_req on mismatch
flush  in  1  synchronous clear of stack (count/pointer to 0); status kept
clr_sts  in  1  synchronous clear of sticky ovf_sts/unf_sts
call_vld  in  1  committed call this cycle
call_link  in  AW  link value to push (call pc+8)
ret_vld  in  1  committed l.jr r9 this cycle
ret_tgt  in  AW  actual return target (operand_b)
chk_vld  out  1  one-cycle pulse: compare result valid
chk_mis  out  1  mismatch, qualified by chk_vld
chk_exp  out  AW  popped expected address, qualified by chk_vld
fault_req  out  1  one-cycle pulse: chk_mis & fault_en
ovf_sts  out  1  sticky: push hit a full stack
unf_sts  out  1  sticky: pop hit an empty stack
occ  out  CW  valid entries, 0..DEPTH

Behaviour:
- Reset (rst=0, async): sp=0, occ=0, chk_vld=0, chk_mis=0, chk_exp=0, fault_req=0, ovf_sts=0, unf_sts=0. Entry array is not reset.
- Accept condition: a strobe is accepted only when rst=1 & !ex_freeze & enable. Otherwise it is dropped and all state is held; chk_vld/fault_req go to 0 next cycle.
- Storage: DEPTH x AW register array, write pointer sp (log2 DEPTH bits, modulo DEPTH). Top entry = mem[sp-1].
- Push, occ<DEPTH: mem[sp]<=call_link, sp++, occ++.
- Push, occ==DEPTH, OVF_WRAP=1: write and advance sp (oldest overwritten), occ stays DEPTH, ovf_sts<=1.
- Push, occ==DEPTH, OVF_WRAP=0: no write, no pointer move, ovf_sts<=1.
- Pop, occ>0: sp--, occ--. Next cycle: chk_vld=1, chk_exp=mem[old sp-1], chk_mis=(chk_exp!=ret_tgt captured at pop). One-cycle latency, registered outputs.
- Pop, occ==0: no pointer move, unf_sts<=1, chk_vld stays 0 (no compare).
- Push and pop in the same cycle: pop/compare uses the pre-push top; the new link is written to the slot vacated by the pop. sp and occ are unchanged, and no ovf/unf is raised if occ>0. If occ==0: unf_sts<=1 and the push proceeds normally.
- fault_req = registered (pop-compare mismatch & fault_en), aligned with chk_vld.
- flush: sp=0, occ=0. A same-cycle push/pop is discarded. Priority: rst > flush > push/pop.
- clr_sts: clears both sticky bits unless the same cycle sets one, in which case set wins.
- Widths: all address compares are full AW bits. occ never exceeds DEPTH. sp wraps silently.

Decomposition:
- Shared package / defines:
  - OR1200_SSTK_DEPTH_DEF and OR1200_SSTK_AW_DEF default values.
  - Opcode constants reused from or1200_defines (JAL, JALR, JR) for the strobe decoder in or1200_ctrl.
- Sub-module: or1200_shadowstk_mem, the DEPTH x AW register file with one write port and one async read port at sp-1. This lets it later map to a generic RAM.

Test Plan:
- DEPTH=4. Push 0x100, 0x200, then ret_tgt 0x200 → next cycle chk_vld=1, chk_exp=0x200, chk_mis=0, occ=1.
- Push 0x100; ret_tgt 0x104 with fault_en=1 → chk_mis=1, fault_req=1 for one cycle, occ=0.
- Pop on empty → unf_sts=1, chk_vld=0, occ=0; then clr_sts → unf_sts=0.
- OVF_WRAP=1, 5 pushes 0x10..0x50:
  - after the 5th push, ovf_sts=1 and occ=4;
  - 4 pops return 0x50, 0x40, 0x30, 0x20, all matching;
  - a 5th pop sets unf_sts.
- OVF_WRAP=0, same 5 pushes → the 5th is dropped; pops return 0x40, 0x30, 0x20, 0x10.
- Push 0xA0 with ex_freeze=1 → occ unchanged.
- Simultaneous push 0xB0 / pop (top 0xA0, tgt 0xA0) → chk_mis=0, occ unchanged, next pop returns 0xB0.
- Assert rst=0 mid-sequence (occ=3) → all outputs 0 immediately (async), occ=0.

Source files
------------

// File: rtl/or1200_shadowstk_rs_pkg.sv
// ----------------------------------------------------------------------------
// or1200_shadowstk_rs_pkg
// Shared definitions for the OR1200 return-address shadow stack:
//   - default geometry (depth / address width)
//   - OR1200 major opcodes used by the call/return strobe decoder in or1200_ctrl
//   - stack operation encoding and the decode helper used by the stack top
// ----------------------------------------------------------------------------
package or1200_shadowstk_rs_pkg;

    localparam int OR1200_SSTK_DEPTH_DEF = 16;
    localparam int OR1200_SSTK_AW_DEF    = 32;

    // Major opcodes (insn[31:26]) mirrored from or1200_defines
    localparam logic [5:0] OR1200_OR32_JAL  = 6'h01;
    localparam logic [5:0] OR1200_OR32_JR   = 6'h11;
    localparam logic [5:0] OR1200_OR32_JALR = 6'h12;

    // Link register used by the return convention (l.jr r9)
    localparam logic [4:0] OR1200_SSTK_LR = 5'd9;

    typedef enum logic [1:0] {
        SSTK_OP_NONE = 2'b00,
        SSTK_OP_PUSH = 2'b01,
        SSTK_OP_POP  = 2'b10,
        SSTK_OP_SWAP = 2'b11
    } sstk_op_e;

    // Fold the accepted call/return strobes into one stack operation
    function automatic sstk_op_e sstk_decode(input logic push, input logic pop);
        sstk_op_e op;
        case ({pop, push})
            2'b01:   op = SSTK_OP_PUSH;
            2'b10:   op = SSTK_OP_POP;
            2'b11:   op = SSTK_OP_SWAP;
            default: op = SSTK_OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/or1200_shadowstk_rs_mem.sv
// ----------------------------------------------------------------------------
// or1200_shadowstk_rs_mem
// DEPTH x AW register file holding the shadow stack entries. One synchronous
// write port, one asynchronous read port. Contents are not reset.
// Ports:
//   clk    in   core clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (the stack top, sp-1)
//   rdata  out  read data, combinational from raddr
// ----------------------------------------------------------------------------
module or1200_shadowstk_rs_mem
    import or1200_shadowstk_rs_pkg::*;
#(
    parameter int AW    = OR1200_SSTK_AW_DEF,
    parameter int DEPTH = OR1200_SSTK_DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem_r [DEPTH];

    // Entry write; storage is deliberately left unreset so it can map to RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/or1200_shadowstk_rs.sv
// ----------------------------------------------------------------------------
// or1200_shadowstk_rs
// Hardware return-address shadow stack beside or1200_ctrl. Committed calls push
// their link address, committed l.jr r9 pops the top entry and compares it with
// the actual return target. The compare result is registered (one cycle after
// the pop) together with an optional fault request to the exception unit.
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   ex_freeze, enable   strobe qualifiers (strobes dropped if frozen/disabled)
//   fault_en            allow fault_req on mismatch
//   flush               synchronous stack clear (status kept)
//   clr_sts             synchronous clear of sticky ovf_sts / unf_sts
//   call_vld/call_link  committed call and its link value
//   ret_vld/ret_tgt     committed return and its actual target
//   chk_vld/chk_mis/chk_exp  compare pulse, mismatch flag, popped address
//   fault_req           mismatch & fault_en, aligned with chk_vld
//   ovf_sts/unf_sts     sticky overflow / underflow status
//   occ                 number of valid entries (0..DEPTH)
// ----------------------------------------------------------------------------
module or1200_shadowstk_rs
    import or1200_shadowstk_rs_pkg::*;
#(
    parameter int AW       = OR1200_SSTK_AW_DEF,
    parameter int DEPTH    = OR1200_SSTK_DEPTH_DEF,
    parameter int CW       = 5,
    parameter int OVF_WRAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_freeze,
    input  logic          enable,
    input  logic          fault_en,
    input  logic          flush,
    input  logic          clr_sts,
    input  logic          call_vld,
    input  logic [AW-1:0] call_link,
    input  logic          ret_vld,
    input  logic [AW-1:0] ret_tgt,
    output logic          chk_vld,
    output logic          chk_mis,
    output logic [AW-1:0] chk_exp,
    output logic          fault_req,
    output logic          ovf_sts,
    output logic          unf_sts,
    output logic [CW-1:0] occ
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] sp_r;
    logic [CW-1:0] occ_r;

    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    logic [PW-1:0] top_addr_s;
    logic [AW-1:0] top_data_s;
    sstk_op_e      op_s;

    logic          we_s;
    logic [PW-1:0] waddr_s;
    logic [PW-1:0] sp_nxt_s;
    logic [CW-1:0] occ_nxt_s;
    logic          cmp_s;
    logic          mis_s;
    logic          ovf_set_s;
    logic          unf_set_s;

    // Flush takes priority over strobes, so it masks them here
    assign accept_s   = !ex_freeze && enable;
    assign push_s     = accept_s && call_vld && !flush;
    assign pop_s      = accept_s && ret_vld && !flush;
    assign empty_s    = (occ_r == {CW{1'b0}});
    assign full_s     = (occ_r == CW'(DEPTH));
    assign top_addr_s = sp_r - PW'(1);
    assign op_s       = sstk_decode(push_s, pop_s);
    assign mis_s      = (top_data_s != ret_tgt);

    // Next-state decode for pointer, occupancy, write port and status set
    always_comb begin
        we_s      = 1'b0;
        waddr_s   = sp_r;
        sp_nxt_s  = sp_r;
        occ_nxt_s = occ_r;
        cmp_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (flush) begin
            sp_nxt_s  = {PW{1'b0}};
            occ_nxt_s = {CW{1'b0}};
        end else begin
            case (op_s)
                SSTK_OP_PUSH: begin
                    if (!full_s) begin
                        we_s      = 1'b1;
                        sp_nxt_s  = sp_r + PW'(1);
                        occ_nxt_s = occ_r + CW'(1);
                    end else if (OVF_WRAP != 0) begin
                        // circular: overwrite the oldest slot, occupancy pinned
                        we_s      = 1'b1;
                        sp_nxt_s  = sp_r + PW'(1);
                        ovf_set_s = 1'b1;
                    end else begin
                        ovf_set_s = 1'b1;
                    end
                end
                SSTK_OP_POP: begin
                    if (!empty_s) begin
                        sp_nxt_s  = top_addr_s;
                        occ_nxt_s = occ_r - CW'(1);
                        cmp_s     = 1'b1;
                    end else begin
                        unf_set_s = 1'b1;
                    end
                end
                SSTK_OP_SWAP: begin
                    if (!empty_s) begin
                        // compare the old top, then reuse its slot for the new link
                        we_s    = 1'b1;
                        waddr_s = top_addr_s;
                        cmp_s   = 1'b1;
                    end else begin
                        // nothing to pop; the push still goes in normally
                        unf_set_s = 1'b1;
                        we_s      = 1'b1;
                        sp_nxt_s  = sp_r + PW'(1);
                        occ_nxt_s = occ_r + CW'(1);
                    end
                end
                SSTK_OP_NONE: begin
                    we_s = 1'b0;
                end
                default: begin
                    we_s = 1'b0;
                end
            endcase
        end
    end

    or1200_shadowstk_rs_mem #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (call_link),
        .raddr (top_addr_s),
        .rdata (top_data_s)
    );

    // Stack pointer and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_r  <= {PW{1'b0}};
            occ_r <= {CW{1'b0}};
        end else begin
            sp_r  <= sp_nxt_s;
            occ_r <= occ_nxt_s;
        end
    end

    // Registered compare result and fault request; chk_exp holds between pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_vld   <= 1'b0;
            chk_mis   <= 1'b0;
            chk_exp   <= {AW{1'b0}};
            fault_req <= 1'b0;
        end else begin
            chk_vld   <= cmp_s;
            chk_mis   <= cmp_s && mis_s;
            fault_req <= cmp_s && mis_s && fault_en;
            if (cmp_s) begin
                chk_exp <= top_data_s;
            end else begin
                chk_exp <= chk_exp;
            end
        end
    end

    // Sticky status: a same-cycle set beats clr_sts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sts <= 1'b0;
            unf_sts <= 1'b0;
        end else begin
            ovf_sts <= ovf_set_s || (ovf_sts && !clr_sts);
            unf_sts <= unf_set_s || (unf_sts && !clr_sts);
        end
    end

    assign occ = occ_r;

endmodule
